// File: rtl/mul_seq_param.sv
// Multi-cycle shift-add multiplier for the Nios II custom-instruction slot.
// Retires BPC multiplier bits per cycle. Supports signed/unsigned operands and high/low word select.

module mul_seq_param #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BPC        = 1,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic [1:0]       n,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int unsigned K  = WIDTH / BPC;
    localparam int unsigned CW = $clog2(K + 1);
    localparam int unsigned PW = 2 * WIDTH;
    localparam bit          EeOn = (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              hi_q, hi_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [PW-1:0]     partial;
    logic [PW-1:0]     prod_fix;
    logic              calc_exit;

    // Magnitudes as unsigned W-bit values; -2^(W-1) maps to 2^(W-1) without overflow.
    always_comb begin
        abs_a = dataa;
        abs_b = datab;
        if (n[0] && dataa[WIDTH-1]) begin
            abs_a = -dataa;
        end
        if (n[0] && datab[WIDTH-1]) begin
            abs_b = -datab;
        end
    end

    // Sum of mcand weighted by the low BPC multiplier bits.
    always_comb begin
        partial = '0;
        for (int b = 0; b < BPC; b++) begin
            if (mplier_q[b]) begin
                partial = partial + (mcand_q << b);
            end
        end
    end

    assign calc_exit = (cnt_q == CW'(K)) || (EeOn && (mplier_q == '0));
    assign prod_fix  = neg_q ? -prod_q : prod_q;

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;

        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (start) begin
                    hi_d     = n[1];
                    mcand_d  = {{WIDTH{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    neg_d    = n[0] & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (calc_exit) begin
                    state_d = StFix;
                end else begin
                    prod_d   = prod_q + partial;
                    mcand_d  = mcand_q << BPC;
                    mplier_d = mplier_q >> BPC;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            StFix: begin
                result_d = hi_q ? prod_fix[PW-1:WIDTH] : prod_fix[WIDTH-1:0];
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            hi_q     <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: three configurations share stimulus and are checked against
// an arithmetic product/latency model derived from the operands alone.

module tb_mul_seq_param;

    logic             clk = 1'b0;
    logic             reset;
    logic             clk_en;
    logic             start;
    logic [31:0]      dataa;
    logic [31:0]      datab;
    logic [1:0]       n;
    logic [2:0][31:0] res_w;
    logic [2:0]       done_w;
    logic [2:0]       busy_w;

    int n_checks = 0;
    int n_fails  = 0;

    int          bpc_c[3] = '{1, 1, 4};
    int          ee_c[3]  = '{0, 1, 1};
    logic [31:0] prev_res[3];
    logic [31:0] exp_res[3];
    int          exp_lat[3];

    always #5 clk = ~clk;

    mul_seq_param #(.WIDTH(32), .BPC(1), .EARLY_EXIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
        .n(n), .result(res_w[0]), .done(done_w[0]), .busy(busy_w[0])
    );
    mul_seq_param #(.WIDTH(32), .BPC(1), .EARLY_EXIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
        .n(n), .result(res_w[1]), .done(done_w[1]), .busy(busy_w[1])
    );
    mul_seq_param #(.WIDTH(32), .BPC(4), .EARLY_EXIT(1)) u_dut2 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
        .n(n), .result(res_w[2]), .done(done_w[2]), .busy(busy_w[2])
    );

    task automatic chk(input string op, input string what, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s/%s dut%0d: observed %h expected %h", op, what, idx, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] nn);
        logic [63:0] xa, xb, p;
        xa = nn[0] ? {{32{a[31]}}, a} : {32'b0, a};
        xb = nn[0] ? {{32{b[31]}}, b} : {32'b0, b};
        p  = xa * xb;
        return nn[1] ? p[63:32] : p[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] b, input logic [1:0] nn,
                                   input int bpc, input int ee);
        logic [31:0] m;
        int top;
        if (ee == 0) return 32 / bpc + 2;
        m = (nn[0] && b[31]) ? -b : b;
        if (m == 0) return 2;
        top = 0;
        for (int i = 0; i < 32; i++) if (m[i]) top = i;
        return top / bpc + 3;
    endfunction

    task automatic begin_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] nn);
        dataa = a;
        datab = b;
        n     = nn;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_res[i] = ref_res(a, b, nn);
            exp_lat[i] = ref_lat(b, nn, bpc_c[i], ee_c[i]);
        end
    endtask

    task automatic check_outputs(input string op, input int eff);
        for (int i = 0; i < 3; i++) begin
            chk(op, "done", i, 32'(done_w[i]), 32'(eff == exp_lat[i]));
            chk(op, "busy", i, 32'(busy_w[i]), 32'(eff < exp_lat[i]));
            chk(op, "result", i, res_w[i], (eff >= exp_lat[i]) ? exp_res[i] : prev_res[i]);
        end
    endtask

    // Runs from the start-sampling edge until every instance has finished; eff counts
    // clk_en edges since sampling, raw counts all clock edges.
    task automatic finish_op(input string op, input int stall_at, input int stall_len,
                             input bit poke, input bit chain);
        int eff, raw, last;
        bit ce, seen0;
        last = 0;
        for (int i = 0; i < 3; i++) if (exp_lat[i] > last) last = exp_lat[i];
        if (!chain) last = last + 1;
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        eff   = 0;
        raw   = 0;
        seen0 = 1'b0;
        check_outputs(op, eff);
        while (eff < last) begin
            raw++;
            n_checks++;
            assert (raw <= 400) else begin
                n_fails++;
                $error("FAIL %s/timeout: observed %0d edges, expected at most 400", op, raw);
            end
            if (raw > 400) break;
            ce = !(raw > stall_at && raw <= stall_at + stall_len);
            clk_en = ce;
            if (poke && raw == 1) begin
                start = 1'b1;
                dataa = $urandom;
                datab = $urandom;
                n     = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            if (ce) eff++;
            @(negedge clk);
            start  = 1'b0;
            clk_en = 1'b1;
            check_outputs(op, eff);
            if (done_w[0] && !seen0) begin
                seen0 = 1'b1;
                if (stall_len > 0 && stall_at < exp_lat[0])
                    chk(op, "stall_delay", 0, 32'(raw), 32'(exp_lat[0] + stall_len));
            end
        end
        for (int i = 0; i < 3; i++) prev_res[i] = exp_res[i];
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        n      = '0;
        for (int i = 0; i < 3; i++) begin
            prev_res[i] = '0;
            exp_res[i]  = '0;
            exp_lat[i]  = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset", "result", i, res_w[i], 32'h0);
            chk("reset", "done", i, 32'(done_w[i]), 32'h0);
            chk("reset", "busy", i, 32'(busy_w[i]), 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);

        begin_op(32'd7, 32'd6, 2'b00);                finish_op("7x6", 0, 0, 0, 0);
        begin_op(-32'sd3, 32'd5, 2'b01);              finish_op("m3x5_01", 0, 0, 0, 0);
        begin_op(-32'sd3, 32'd5, 2'b11);              finish_op("m3x5_11", 0, 0, 0, 0);
        begin_op(-32'sd3, 32'd5, 2'b10);              finish_op("m3x5_10", 0, 0, 0, 0);
        begin_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10); finish_op("ffxff_10", 0, 0, 0, 0);
        begin_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00); finish_op("ffxff_00", 0, 0, 0, 0);
        begin_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11); finish_op("ffxff_11", 0, 0, 0, 0);
        begin_op(32'h8000_0000, 32'h8000_0000, 2'b11); finish_op("min2_11", 0, 0, 0, 0);
        begin_op(32'h8000_0000, 32'h8000_0000, 2'b01); finish_op("min2_01", 0, 0, 0, 0);
        begin_op(32'h1234_5678, 32'h0, 2'b00);         finish_op("b_zero", 0, 0, 0, 0);
        begin_op(32'h1234_5678, 32'h1, 2'b00);         finish_op("b_one", 0, 0, 0, 0);
        begin_op(32'hDEAD_BEEF, 32'hF0, 2'b01);        finish_op("b_f0", 0, 0, 0, 0);

        // Stall mid-CALC, then a stall while done is high.
        begin_op($urandom, 32'h8000_0001, 2'b00);      finish_op("stall_calc", 3, 5, 0, 0);
        begin_op($urandom, 32'h4000_0003, 2'b10);      finish_op("stall_done", 34, 4, 0, 0);

        begin_op($urandom, $urandom | 32'h8000_0000, 2'b00); finish_op("poke_busy", 0, 0, 1, 0);

        ra = $urandom;
        rb = $urandom;
        begin_op(ra, rb, 2'b11);                       finish_op("chain_a", 0, 0, 0, 1);
        begin_op(rb, ra, 2'b01);                       finish_op("chain_b", 0, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            begin_op(ra, rb, 2'($urandom_range(0, 3)));
            finish_op("random", 0, 0, 0, 0);
        end

        // Asynchronous reset in the middle of an operation.
        begin_op($urandom, 32'hFFFF_FFFF, 2'b00);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_rst", "result", i, res_w[i], 32'h0);
            chk("async_rst", "done", i, 32'(done_w[i]), 32'h0);
            chk("async_rst", "busy", i, 32'(busy_w[i]), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("post_rst", "done", i, 32'(done_w[i]), 32'h0);
                chk("post_rst", "busy", i, 32'(busy_w[i]), 32'h0);
            end
        end
        for (int i = 0; i < 3; i++) prev_res[i] = '0;
        begin_op($urandom, $urandom, 2'b01);           finish_op("after_rst", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
